// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for initiators, targets and the crossbar bench.
//   - bus width constants
//   - bridge state encoding
//   - packed request/response records
//   - helper that sizes watchdog counters
package wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
  } req_t;

  typedef struct packed {
    logic [WB_DW-1:0] dat;
    logic             err;
    logic             timeout;
  } rsp_t;

  // Counter width able to hold 0..timeout, never narrower than one bit.
  function automatic int tw_of(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog counter for Wishbone cycles.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the count at zero
//   enable     : count one more cycle without termination
//   expire     : this edge is the TIMEOUT-th counted cycle (never when TIMEOUT=0)
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = tw_of(TIMEOUT);
  localparam logic [TW-1:0] LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready request/response to Wishbone classic single-cycle initiator.
//   req_*   : request channel (valid/ready, we, sel, adr, dat)
//   rsp_*   : response channel (valid/ready, dat, err, timeout)
//   busy    : a transaction is in flight or its response is pending
//   m_*     : Wishbone master port (cyc, stb, we, sel, adr, dat_w, dat_r, ack, err)
//
// state | meaning
// IDLE  | ready for a request, no bus activity
// BUS   | cyc/stb asserted, waiting for ack/err or watchdog expiry
// RESP  | response held on rsp_* until rsp_ready
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WB_SELW-1:0] req_sel,
  input  logic [WB_AW-1:0]  req_adr,
  input  logic [WB_DW-1:0]  req_dat,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WB_DW-1:0]  rsp_dat,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [WB_SELW-1:0] m_sel,
  output logic [WB_AW-1:0]  m_adr,
  output logic [WB_DW-1:0]  m_dat_w,
  input  logic [WB_DW-1:0]  m_dat_r,
  input  logic              m_ack,
  input  logic              m_err
);

  wb_state_e state, state_nxt;
  req_t      req_q;
  rsp_t      rsp_q;
  logic      accept;
  logic      term;
  logic      expire;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign term      = m_ack || m_err;

  // Cleared whenever outside BUS, so every bus cycle starts counting from zero.
  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != BUS),
    .enable ((state == BUS) && !term),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (req_sel == '0) ? RESP : BUS;
      BUS:  if (term || expire) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An empty byte-select request is refused without touching the bus,
          // so the bus-side registers keep their previous contents.
          if (accept) begin
            if (req_sel != '0) begin
              req_q.we  <= req_we;
              req_q.sel <= req_sel;
              req_q.adr <= req_adr;
              req_q.dat <= req_dat;
            end
            rsp_q.dat     <= '0;
            rsp_q.err     <= (req_sel == '0);
            rsp_q.timeout <= 1'b0;
          end
        end
        BUS: begin
          // err takes priority over ack; a termination on the expiry edge wins
          // over the watchdog.
          if (m_err) begin
            rsp_q.dat     <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b0;
          end else if (m_ack) begin
            rsp_q.dat     <= req_q.we ? '0 : m_dat_r;
            rsp_q.err     <= 1'b0;
            rsp_q.timeout <= 1'b0;
          end else if (expire) begin
            rsp_q.dat     <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_q <= '0;
        default: rsp_q <= '0;
      endcase
    end
  end

  assign rsp_valid   = (state == RESP);
  assign rsp_dat     = rsp_q.dat;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = (state != IDLE);

  assign m_cyc   = (state == BUS);
  assign m_stb   = (state == BUS);
  assign m_we    = req_q.we;
  assign m_sel   = req_q.sel;
  assign m_adr   = req_q.adr;
  assign m_dat_w = req_q.dat;

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;

  localparam int TO     = 8;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_HANG = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat_w;
  logic [31:0] m_dat_r = '0;
  logic        m_ack = 1'b0;
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  wb_master_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .m_err(m_err)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One request through the bridge with a scripted slave.
  // waits: wait states before termination; bp: cycles of rsp_ready=0.
  task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [31:0] rdata,
                     input int waits, input int mode, input int bp);
    exp_t e;
    exp_t got;
    int   exp_stb;
    int   stb_n;
    int   k;
    bit   to;
    to = (sel != 4'd0) && ((mode == M_HANG) || (waits + 1 > TO));
    if (sel == 4'd0) begin
      e.dat = '0; e.err = 1'b1; e.to = 1'b0; exp_stb = 0;
    end else if (to) begin
      e.dat = '0; e.err = 1'b1; e.to = 1'b1; exp_stb = TO;
    end else begin
      exp_stb = waits + 1;
      e.dat = (mode == M_ACK && !we) ? rdata : 32'h0;
      e.err = (mode != M_ACK);
      e.to  = 1'b0;
    end
    sb.push_back(e);

    req_valid = 1'b1; req_we = we; req_sel = sel; req_adr = adr; req_dat = dat;
    m_dat_r = rdata;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    // Scramble the request inputs to show the bridge uses its latched copy.
    req_valid = 1'b0; req_we = ~we; req_sel = ~sel; req_adr = ~adr; req_dat = ~dat;

    stb_n = 0;
    k = 0;
    while (m_stb && k < 40) begin
      stb_n++;
      check("cyc_with_stb", {31'd0, m_cyc}, 32'd1);
      check("m_we", {31'd0, m_we}, {31'd0, we});
      check("m_sel", {28'd0, m_sel}, {28'd0, sel});
      check("m_adr", m_adr, adr);
      check("m_dat_w", m_dat_w, dat);
      check("req_ready_bus", {31'd0, req_ready}, 32'd0);
      if (stb_n == waits + 1 && mode != M_HANG) begin
        m_ack = (mode != M_ERR);
        m_err = (mode != M_ACK);
      end
      @(negedge clk);
      m_ack = 1'b0;
      m_err = 1'b0;
      k++;
    end
    if (k >= 40) $display("FAIL stb_bound: observed=%0d expected<40", k);
    check("stb_cycles", stb_n, exp_stb);
    check("cyc_dropped", {31'd0, m_cyc}, 32'd0);
    check("rsp_valid_up", {31'd0, rsp_valid}, 32'd1);

    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_sel = 4'hF; req_adr = 32'h5555_0000 + i;
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, e.dat);
      check("bp_rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      check("bp_no_cyc", {31'd0, m_cyc}, 32'd0);
      @(negedge clk);
    end

    rsp_ready = 1'b1;
    check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("rsp_dat", rsp_dat, got.dat);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, got.err});
      check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, got.to});
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("rsp_valid_down", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
    check("rsp_clear", {rsp_dat[29:0], rsp_err, rsp_timeout}, 32'd0);
    check("no_cyc_after", {31'd0, m_cyc}, 32'd0);
  endtask

  initial begin
    #1;
    check("rst_cyc", {31'd0, m_cyc}, 32'd0);
    check("rst_stb", {31'd0, m_stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_fields", {rsp_dat[29:0], rsp_err, rsp_timeout}, 32'd0);
    check("rst_m_adr", m_adr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 4'hF, 32'h3000_0010, 32'h0,         32'hDEAD_BEEF, 0, M_ACK,  0);
    txn(1'b1, 4'h3, 32'h3000_0004, 32'h1234_5678, 32'hCAFE_F00D, 3, M_ACK,  0);
    txn(1'b0, 4'hF, 32'h3000_0020, 32'h0,         32'h1111_1111, 0, M_HANG, 0);
    txn(1'b0, 4'hF, 32'h3000_0024, 32'h0,         32'h2222_2222, 7, M_ACK,  0);
    txn(1'b0, 4'hF, 32'h3000_0028, 32'h0,         32'h3333_3333, 1, M_ERR,  0);
    txn(1'b0, 4'hC, 32'h3000_002C, 32'h0,         32'h4444_4444, 0, M_BOTH, 0);
    txn(1'b1, 4'h0, 32'h3000_0030, 32'hAAAA_5555, 32'h5555_5555, 0, M_ACK,  0);
    check("sel0_bus_regs_held", m_adr, 32'h3000_002C);
    txn(1'b0, 4'hF, 32'h3000_0040, 32'h0,         32'h6666_7777, 2, M_ACK,  5);
    txn(1'b1, 4'h8, 32'h3000_0044, 32'h8765_4321, 32'h0,         1, M_ACK,  0);
    check("bus_regs_hold_idle", m_dat_w, 32'h8765_4321);

    // Reset while the slave stalls.
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; req_adr = 32'h3000_0050;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_stb", {31'd0, m_stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_cyc", {31'd0, m_cyc}, 32'd0);
    check("async_stb", {31'd0, m_stb}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_cyc", {31'd0, m_cyc}, 32'd0);

    txn(1'b0, 4'hF, 32'h3000_0060, 32'h0, 32'h0BAD_CAFE, 0, M_ACK, 0);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
